fifo_wr_arbiter_ctrl: RTL and testbench
=======================================

// Module: fifo_wr_arbiter_ctrl
// PURPOSE
//   Pointer controller and two-port write arbiter for a shared 2**ADDR_W-entry FIFO RAM.
//   Round-robins two write requesters onto one RAM write port and serves one reader.
//   Owns the wrap-bit pointers and derives Full/Empty from them.
//   Sits between the requesting agents and the synchronous dual-port FIFO memory.
// PARAMETERS
//   ADDR_W  8  RAM address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits
//   DATA_W  8  write data width
// PORTS
//   clk        in   1         single clock, rising edge
//   rst_n      in   1         asynchronous, active-low reset
//   REQ0       in   1         requester 0 write request
//   DIN0       in   DATA_W    requester 0 write data
//   GNT0       out  1         requester 0 grant; write accepted at this clock edge
//   REQ1       in   1         requester 1 write request
//   DIN1       in   DATA_W    requester 1 write data
//   GNT1       out  1         requester 1 grant
//   RD_REQ     in   1         reader pop request
//   RAM_WE     out  1         RAM write enable
//   RAM_WADDR  out  ADDR_W    RAM write address = WR_PTR[ADDR_W-1:0]
//   RAM_WDATA  out  DATA_W    muxed DIN of the granted requester
//   RAM_RE     out  1         RAM read enable; data valid on RAM output 1 cycle later
//   RAM_RADDR  out  ADDR_W    RAM read address = RD_PTR[ADDR_W-1:0]
//   WR_PTR     out  ADDR_W+1  write pointer, MSB is wrap bit
//   RD_PTR     out  ADDR_W+1  read pointer, MSB is wrap bit
//   Full       out  1         MSBs differ and lower bits equal
//   Empty      out  1         MSBs equal and lower bits equal
//   COUNT      out  ADDR_W+1  WR_PTR - RD_PTR mod 2**(ADDR_W+1); range 0..2**ADDR_W
// BEHAVIOUR
//   - Reset (async, rst_n=0): WR_PTR=RD_PTR=0, PRIO=0 (REQ0 favoured), COUNT=0, Empty=1, Full=0.
//     GNT0/GNT1/RAM_WE/RAM_RE forced 0 while rst_n=0. Reset mid-transfer discards all contents.
//   - Grants are combinational from REQx, PRIO and registered Full; zero-cycle latency.
//   - Arbitration: both GNTs 0 if Full. Single request -> granted. Both requesting -> PRIO side granted.
//   - PRIO register: after any grant, PRIO <= index of the non-granted port.
//     PRIO is unchanged on cycles with no grant.
//   - At most one of GNT0/GNT1 high. RAM_WE = GNT0|GNT1. RAM_WDATA = GNT1 ? DIN1 : DIN0.
//   - Write accepted: WR_PTR <= WR_PTR+1 at the edge. Read accepted: RD_REQ & ~Empty;
//     RAM_RE=1, RD_PTR <= RD_PTR+1.
//   - Pointer arithmetic is modulo 2**(ADDR_W+1). Default width wraps 511 -> 0 and toggles the
//     wrap bit. The RAM address wraps 255 -> 0.
//   - Full/Empty/COUNT are combinational from the registered pointers and reflect the post-edge state.
//   - Simultaneous write + read, not Full/Empty: both pointers advance; COUNT unchanged.
//   - Full + write req + read: write blocked this cycle, read proceeds; Full=0 next cycle.
//   - Empty + write + read: read blocked, write proceeds; Empty=0 next cycle.
//     Data is readable from the following cycle; there is no bypass.
//   - Requester holds REQx/DINx until it sees GNTx. There is no request queueing.
// CONFIGURATION
//   FIFO_ERR_FLAG_EN defined: adds out ports OVF and UDF (1 bit each, reset 0).
//     - OVF sets sticky when any REQx=1 while Full=1.
//     - UDF sets sticky when RD_REQ=1 while Empty=1.
//     - Both clear only on reset.
//   Undefined: ports and logic absent. Blocked requests are silently stalled.
// TESTING
//   1 Reset then idle: Empty=1, Full=0, COUNT=0, PTRs=0, all grants/enables 0.
//   2 REQ0=REQ1=1 for 4 cycles, Empty start: GNT order 0,1,0,1; WR_PTR=4; COUNT=4; PRIO=0.
//   3 REQ1 only for 256 cycles: Full=1 at WR_PTR=256, RD_PTR=0; next REQ1 -> GNT1=0, WR_PTR stays 256.
//   4 Full + REQ0 + RD_REQ same cycle: GNT0=0, RAM_RE=1, RD_PTR=1, COUNT=255, Full=0 next.
//   5 Wrap: fill/drain until WR_PTR=511; one write+read -> WR_PTR=0, RAM_WADDR=0, Empty per MSBs.
//   6 Assert rst_n=0 with COUNT=10 mid-burst: PTRs=0, Empty=1 immediately; with FIFO_ERR_FLAG_EN,
//     RD_REQ on Empty -> UDF=1 and it stays set.

Source files
------------

// File: rtl/fifo_wr_arbiter_ctrl.sv
// fifo_wr_arbiter_ctrl
//   Pointer controller and two-port round-robin write arbiter for a shared
//   2**ADDR_W-entry FIFO RAM. Two requesters share one RAM write port, and one
//   reader pops. The block owns the wrap-bit pointers and derives Full, Empty
//   and COUNT from them.
//
//   Ports:
//     clk, rst_n              clock (rising edge), async active-low reset
//     REQ0/DIN0/GNT0          requester 0 request, data, combinational grant
//     REQ1/DIN1/GNT1          requester 1 request, data, combinational grant
//     RD_REQ                  reader pop request
//     RAM_WE/WADDR/WDATA      RAM write port
//     RAM_RE/RADDR            RAM read port (RAM data valid one cycle later)
//     WR_PTR, RD_PTR          ADDR_W+1 bit pointers, MSB is the wrap bit
//     Full, Empty, COUNT      occupancy, derived from the registered pointers
//
//   Optional feature macro: FIFO_ERR_FLAG_EN
//     Adds sticky OVF (request while Full) and UDF (pop while Empty) outputs.
//     These flags clear only on reset.
module fifo_wr_arbiter_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              REQ0,
  input  logic [DATA_W-1:0] DIN0,
  output logic              GNT0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] DIN1,
  output logic              GNT1,
  input  logic              RD_REQ,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              RAM_RE,
  output logic [ADDR_W-1:0] RAM_RADDR,
  output logic [ADDR_W:0]   WR_PTR,
  output logic [ADDR_W:0]   RD_PTR,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   COUNT
`ifdef FIFO_ERR_FLAG_EN
  ,
  output logic              OVF,
  output logic              UDF
`endif
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             prio_q, prio_d;
  logic             full_c, empty_c;
  logic             gnt0_c, gnt1_c, we_c, re_c;

  // Occupancy from the registered pointers only
  always_comb begin
    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
              (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  end

  // Arbitration; grants and enables are held low while reset is asserted
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rst_n && !full_c) begin
      if (REQ0 && REQ1) begin
        gnt0_c = !prio_q;
        gnt1_c = prio_q;
      end else begin
        gnt0_c = REQ0;
        gnt1_c = REQ1;
      end
    end
    we_c = gnt0_c | gnt1_c;
    re_c = rst_n & RD_REQ & !empty_c;
  end

  // Next-state: pointers advance on accepted transfers, priority flips to the loser
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    prio_d   = prio_q;
    if (we_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (re_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (gnt0_c) begin
      prio_d = 1'b1;
    end else if (gnt1_c) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      prio_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      prio_q   <= prio_d;
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags, judged against the registered Full/Empty
  always_comb begin
    ovf_d = ovf_q | ((REQ0 | REQ1) & full_c);
    udf_d = udf_q | (RD_REQ & empty_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign OVF = ovf_q;
  assign UDF = udf_q;
`endif

  assign GNT0      = gnt0_c;
  assign GNT1      = gnt1_c;
  assign RAM_WE    = we_c;
  assign RAM_WADDR = wr_ptr_q[ADDR_W-1:0];
  assign RAM_WDATA = gnt1_c ? DIN1 : DIN0;
  assign RAM_RE    = re_c;
  assign RAM_RADDR = rd_ptr_q[ADDR_W-1:0];
  assign WR_PTR    = wr_ptr_q;
  assign RD_PTR    = rd_ptr_q;
  assign Full      = full_c;
  assign Empty     = empty_c;
  assign COUNT     = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// Directed bench for fifo_wr_arbiter_ctrl: a vector table for the arbitration
// and pointer basics, then hand sequences for fill/Full, wrap and mid-burst reset.
module tb_fifo_wr_arbiter_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1, rd_req;
  logic [DATA_W-1:0] din0, din1;
  logic              gnt0, gnt1, ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W:0]   wr_ptr, rd_ptr, count;
  logic              full, empty;
`ifdef FIFO_ERR_FLAG_EN
  logic              ovf, udf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_arbiter_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .REQ0(req0), .DIN0(din0), .GNT0(gnt0),
    .REQ1(req1), .DIN1(din1), .GNT1(gnt1),
    .RD_REQ(rd_req),
    .RAM_WE(ram_we), .RAM_WADDR(ram_waddr), .RAM_WDATA(ram_wdata),
    .RAM_RE(ram_re), .RAM_RADDR(ram_raddr),
    .WR_PTR(wr_ptr), .RD_PTR(rd_ptr),
    .Full(full), .Empty(empty), .COUNT(count)
`ifdef FIFO_ERR_FLAG_EN
    , .OVF(ovf), .UDF(udf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       req0;
    logic [7:0] din0;
    logic       req1;
    logic [7:0] din1;
    logic       rd;
    logic       g0;
    logic       g1;
    logic [7:0] wdata;
    logic       re;
    logic [7:0] waddr;
    logic [7:0] raddr;
    logic [8:0] wr;
    logic [8:0] rdp;
    logic [8:0] cnt;
    logic       emp;
    logic       ful;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [7:0] d0, input logic r1,
                       input logic [7:0] d1, input logic rd);
    req0 = r0; din0 = d0; req1 = r1; din1 = d1; rd_req = rd;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Table: reset state, round-robin, single requests, concurrent read, idle-cycle priority hold
    //          r0  d0     r1  d1     rd   g0  g1  wdata  re  waddr  raddr  wr  rd  cnt emp ful
    vecs[0]  = '{0, 8'h00, 0, 8'h00, 0,   0,  0,  8'h00, 0,  8'd0,  8'd0,  0,  0,  0,  1,  0};
    vecs[1]  = '{1, 8'hA1, 1, 8'hB1, 0,   1,  0,  8'hA1, 0,  8'd0,  8'd0,  1,  0,  1,  0,  0};
    vecs[2]  = '{1, 8'hA2, 1, 8'hB2, 0,   0,  1,  8'hB2, 0,  8'd1,  8'd0,  2,  0,  2,  0,  0};
    vecs[3]  = '{1, 8'hA3, 1, 8'hB3, 0,   1,  0,  8'hA3, 0,  8'd2,  8'd0,  3,  0,  3,  0,  0};
    vecs[4]  = '{1, 8'hA4, 1, 8'hB4, 0,   0,  1,  8'hB4, 0,  8'd3,  8'd0,  4,  0,  4,  0,  0};
    vecs[5]  = '{1, 8'hA5, 1, 8'hB5, 0,   1,  0,  8'hA5, 0,  8'd4,  8'd0,  5,  0,  5,  0,  0};
    vecs[6]  = '{0, 8'hA6, 1, 8'hB6, 1,   0,  1,  8'hB6, 1,  8'd5,  8'd0,  6,  1,  5,  0,  0};
    vecs[7]  = '{1, 8'hC7, 0, 8'hD7, 0,   1,  0,  8'hC7, 0,  8'd6,  8'd1,  7,  1,  6,  0,  0};
    vecs[8]  = '{1, 8'hC8, 1, 8'hD8, 1,   0,  1,  8'hD8, 1,  8'd7,  8'd1,  8,  2,  6,  0,  0};
    vecs[9]  = '{0, 8'h11, 0, 8'h22, 1,   0,  0,  8'h11, 1,  8'd8,  8'd2,  8,  3,  5,  0,  0};
    vecs[10] = '{1, 8'h33, 1, 8'h44, 0,   1,  0,  8'h33, 0,  8'd8,  8'd3,  9,  3,  6,  0,  0};

    rst_n = 1'b0;
    drive(1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
    #12;
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_re", 32'(ram_re), 0);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    #2;
    chk("idle_empty", 32'(empty), 1);
    chk("idle_full", 32'(full), 0);
    chk("idle_count", 32'(count), 0);
    chk("idle_wrptr", 32'(wr_ptr), 0);
    chk("idle_rdptr", 32'(rd_ptr), 0);
    step();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].req0, vecs[i].din0, vecs[i].req1, vecs[i].din1, vecs[i].rd);
      #2;
      chk($sformatf("v%0d_gnt0", i), 32'(gnt0), 32'(vecs[i].g0));
      chk($sformatf("v%0d_gnt1", i), 32'(gnt1), 32'(vecs[i].g1));
      chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(vecs[i].g0 | vecs[i].g1));
      chk($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(vecs[i].wdata));
      chk($sformatf("v%0d_re", i), 32'(ram_re), 32'(vecs[i].re));
      chk($sformatf("v%0d_waddr", i), 32'(ram_waddr), 32'(vecs[i].waddr));
      chk($sformatf("v%0d_raddr", i), 32'(ram_raddr), 32'(vecs[i].raddr));
      step();
      chk($sformatf("v%0d_wrptr", i), 32'(wr_ptr), 32'(vecs[i].wr));
      chk($sformatf("v%0d_rdptr", i), 32'(rd_ptr), 32'(vecs[i].rdp));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].ful));
    end

    // Fill with requester 1 alone until Full
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'(i), 1'b0);
      #2;
      chk("fill_gnt1", 32'(gnt1), 1);
      chk("fill_waddr", 32'(ram_waddr), 32'(i));
      step();
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_wrptr", 32'(wr_ptr), 256);
    chk("fill_rdptr", 32'(rd_ptr), 0);
    chk("fill_count", 32'(count), 256);
    chk("fill_empty", 32'(empty), 0);
    drive(1'b0, 8'h00, 1'b1, 8'hEE, 1'b0);
    #2;
    chk("full_gnt1", 32'(gnt1), 0);
    chk("full_we", 32'(ram_we), 0);
    step();
    chk("full_wrptr_hold", 32'(wr_ptr), 256);
`ifdef FIFO_ERR_FLAG_EN
    chk("full_ovf", 32'(ovf), 1);
`endif

    // Full with a write and a read in the same cycle: only the read goes
    drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    #2;
    chk("fr_gnt0", 32'(gnt0), 0);
    chk("fr_re", 32'(ram_re), 1);
    chk("fr_raddr", 32'(ram_raddr), 0);
    step();
    chk("fr_rdptr", 32'(rd_ptr), 1);
    chk("fr_count", 32'(count), 255);
    chk("fr_full", 32'(full), 0);

    // Concurrent write+read up to WR_PTR=511, then across the wrap
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
      #2;
      if (!(gnt0 && ram_re)) chk("wr_rd_both", 32'({gnt0, ram_re}), 32'h3);
      step();
    end
    chk("pre_wrap_wrptr", 32'(wr_ptr), 511);
    chk("pre_wrap_rdptr", 32'(rd_ptr), 256);
    chk("pre_wrap_count", 32'(count), 255);
    drive(1'b1, 8'h99, 1'b0, 8'h00, 1'b1);
    #2;
    chk("wrap_waddr_pre", 32'(ram_waddr), 255);
    step();
    chk("wrap_wrptr", 32'(wr_ptr), 0);
    chk("wrap_waddr", 32'(ram_waddr), 0);
    chk("wrap_rdptr", 32'(rd_ptr), 257);
    chk("wrap_count", 32'(count), 255);
    chk("wrap_empty", 32'(empty), 0);
    chk("wrap_full", 32'(full), 0);

    // Drain to Empty across the read-pointer wrap
    for (int i = 0; i < 255; i++) begin
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      step();
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_rdptr", 32'(rd_ptr), 0);
    chk("drain_count", 32'(count), 0);

    // Empty with write and read together: only the write goes, no bypass
    drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    #2;
    chk("ew_gnt0", 32'(gnt0), 1);
    chk("ew_re", 32'(ram_re), 0);
    step();
    chk("ew_empty", 32'(empty), 0);
    chk("ew_count", 32'(count), 1);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    #2;
    chk("er_re", 32'(ram_re), 1);
    chk("er_raddr", 32'(ram_raddr), 0);
    step();
    chk("er_empty", 32'(empty), 1);

    // Mid-burst reset with COUNT=10
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
      step();
    end
    chk("burst_count", 32'(count), 10);
    drive(1'b1, 8'hF0, 1'b1, 8'hF1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_wrptr", 32'(wr_ptr), 0);
    chk("mrst_rdptr", 32'(rd_ptr), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_gnt0", 32'(gnt0), 0);
    chk("mrst_gnt1", 32'(gnt1), 0);
    chk("mrst_we", 32'(ram_we), 0);
    step();
    chk("mrst_hold_wrptr", 32'(wr_ptr), 0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    rst_n = 1'b1;
    #2;
    chk("post_rst_re", 32'(ram_re), 0);
    step();
    chk("post_rst_rdptr", 32'(rd_ptr), 0);
`ifdef FIFO_ERR_FLAG_EN
    chk("udf_set", 32'(udf), 1);
    chk("ovf_clear", 32'(ovf), 0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    step();
    chk("udf_sticky", 32'(udf), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
